ddr3_line_bridge: RTL and testbench

Responder side of the 256-bit cache-line interface driven by `ddr3_cache_ctrl`. It accepts one line read or line write at a time and converts it into two 128-bit beats on a MIG 7-series user (app) interface. It reassembles read beats into a full line and returns a single-cycle `ack_o`. It sits between `ddr3_cache_ctrl` and the MIG core, replacing the behavioural DDR3 model used in simulation.

---
 rtl/ddr3_line_bridge.sv | 241 ++++++++++++++++++++++++
 tb/tb_ddr3_line_bridge.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_line_bridge.sv
// ddr3_line_bridge
//   Responder for the 256-bit cache-line interface of ddr3_cache_ctrl. Each
//   line read or write is split into two 128-bit beats on the MIG 7-series
//   app interface; read beats are reassembled into data_o. ack_o pulses once
//   per completed line and once when calibration finishes.
//
//   Ports
//     clk, rst                  : MIG ui_clk, asynchronous active-high reset
//     addr_i[28:0]              : line index (32-byte granule)
//     data_i[255:0] / data_o    : write line / last completed read line
//     we_i, rd_i                : requests, held until ack_o (write wins)
//     ack_o                     : one-cycle completion pulse
//     err_o                     : sticky timeout flag
//     init_calib_complete       : MIG calibration done
//     app_*                     : MIG user interface (command, write data, read data)
//
//   Optional build macro DDR3_BRIDGE_WATCHDOG_EN: abort WRITE/READ after
//   TIMEOUT_CYCLES with an ack_o pulse and err_o set. Undefined: err_o = 0.
module ddr3_line_bridge #(
    parameter int unsigned APP_ADDR_WIDTH = 27,
    parameter int unsigned APP_DATA_WIDTH = 128,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [28:0]                   addr_i,
    input  logic [255:0]                  data_i,
    output logic [255:0]                  data_o,
    input  logic                          we_i,
    input  logic                          rd_i,
    output logic                          ack_o,
    output logic                          err_o,
    input  logic                          init_calib_complete,
    output logic [APP_ADDR_WIDTH-1:0]     app_addr,
    output logic [2:0]                    app_cmd,
    output logic                          app_en,
    input  logic                          app_rdy,
    output logic [APP_DATA_WIDTH-1:0]     app_wdf_data,
    output logic [APP_DATA_WIDTH/8-1:0]   app_wdf_mask,
    output logic                          app_wdf_wren,
    output logic                          app_wdf_end,
    input  logic                          app_wdf_rdy,
    input  logic [APP_DATA_WIDTH-1:0]     app_rd_data,
    input  logic                          app_rd_data_valid
);

    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;
    // One 128-bit beat spans 8 x16 words.
    localparam logic [APP_ADDR_WIDTH-1:0] BEAT_STRIDE = APP_ADDR_WIDTH'(8);

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_WRITE, S_READ, S_ACK, S_RELEASE
    } state_t;

    state_t                      state, state_n;
    logic [1:0]                  cmd_cnt, cmd_cnt_n;
    logic [1:0]                  wdf_cnt, wdf_cnt_n;
    logic [1:0]                  rd_cnt, rd_cnt_n;
    logic [APP_DATA_WIDTH-1:0]   wdata_hi, wdata_hi_n;
    logic [APP_ADDR_WIDTH-1:0]   app_addr_n;
    logic [2:0]                  app_cmd_n;
    logic                        app_en_n;
    logic [APP_DATA_WIDTH-1:0]   app_wdf_data_n;
    logic                        app_wdf_wren_n;
    logic                        app_wdf_end_n;
    logic [255:0]                data_o_n;
    logic                        ack_n;
    logic [APP_ADDR_WIDTH-1:0]   line_base;
    logic                        unused_addr_hi;

    assign line_base      = {addr_i[APP_ADDR_WIDTH-5:0], 4'b0000};
    assign unused_addr_hi = ^addr_i[28:APP_ADDR_WIDTH-4];
    assign app_wdf_mask   = '0;

`ifdef DDR3_BRIDGE_WATCHDOG_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt, wd_cnt_n;
    logic            err_n;
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT_CYCLES);
    assign err_o          = 1'b0;
`endif

    always_comb begin
        state_n        = state;
        cmd_cnt_n      = cmd_cnt;
        wdf_cnt_n      = wdf_cnt;
        rd_cnt_n       = rd_cnt;
        wdata_hi_n     = wdata_hi;
        app_addr_n     = app_addr;
        app_cmd_n      = app_cmd;
        app_en_n       = app_en;
        app_wdf_data_n = app_wdf_data;
        app_wdf_wren_n = app_wdf_wren;
        data_o_n       = data_o;
        ack_n          = 1'b0;
`ifdef DDR3_BRIDGE_WATCHDOG_EN
        wd_cnt_n       = '0;
        err_n          = err_o;
`endif
        case (state)
            S_INIT: begin
                if (init_calib_complete) begin
                    state_n = S_ACK;
                    ack_n   = 1'b1;
                end
            end
            S_IDLE: begin
                cmd_cnt_n  = '0;
                wdf_cnt_n  = '0;
                rd_cnt_n   = '0;
                wdata_hi_n = data_i[2*APP_DATA_WIDTH-1:APP_DATA_WIDTH];
                if (we_i) begin
                    state_n        = S_WRITE;
                    app_en_n       = 1'b1;
                    app_cmd_n      = CMD_WRITE;
                    app_addr_n     = line_base;
                    app_wdf_wren_n = 1'b1;
                    app_wdf_data_n = data_i[APP_DATA_WIDTH-1:0];
                end else if (rd_i) begin
                    state_n    = S_READ;
                    app_en_n   = 1'b1;
                    app_cmd_n  = CMD_READ;
                    app_addr_n = line_base;
                end
            end
            S_WRITE: begin
                // Command and data channels progress independently.
                if (app_en && app_rdy) begin
                    cmd_cnt_n = cmd_cnt + 2'd1;
                    if (cmd_cnt == 2'd0) app_addr_n = app_addr + BEAT_STRIDE;
                    else                 app_en_n   = 1'b0;
                end
                if (app_wdf_wren && app_wdf_rdy) begin
                    wdf_cnt_n = wdf_cnt + 2'd1;
                    if (wdf_cnt == 2'd0) app_wdf_data_n = wdata_hi;
                    else                 app_wdf_wren_n = 1'b0;
                end
                if (cmd_cnt_n == 2'd2 && wdf_cnt_n == 2'd2) begin
                    state_n = S_ACK;
                    ack_n   = 1'b1;
                end
            end
            S_READ: begin
                if (app_en && app_rdy) begin
                    cmd_cnt_n = cmd_cnt + 2'd1;
                    if (cmd_cnt == 2'd0) app_addr_n = app_addr + BEAT_STRIDE;
                    else                 app_en_n   = 1'b0;
                end
                if (app_rd_data_valid) begin
                    rd_cnt_n = rd_cnt + 2'd1;
                    if (rd_cnt == 2'd0) data_o_n[APP_DATA_WIDTH-1:0]                = app_rd_data;
                    else                data_o_n[2*APP_DATA_WIDTH-1:APP_DATA_WIDTH] = app_rd_data;
                end
                if (rd_cnt_n == 2'd2) begin
                    state_n  = S_ACK;
                    ack_n    = 1'b1;
                    app_en_n = 1'b0;
                end
            end
            S_ACK: begin
                state_n   = S_RELEASE;
                cmd_cnt_n = '0;
                wdf_cnt_n = '0;
                rd_cnt_n  = '0;
            end
            S_RELEASE: begin
                // Wait for the requester to drop so a held request is not served twice.
                if (!we_i && !rd_i) state_n = S_IDLE;
            end
            default: state_n = S_INIT;
        endcase
`ifdef DDR3_BRIDGE_WATCHDOG_EN
        // Counter value equals cycles elapsed since the request was accepted.
        if (state == S_IDLE && (state_n == S_WRITE || state_n == S_READ)) begin
            wd_cnt_n = WD_W'(1);
        end else if ((state == S_WRITE || state == S_READ) && state_n == state) begin
            if (wd_cnt >= WD_W'(TIMEOUT_CYCLES - 1)) begin
                state_n        = S_ACK;
                ack_n          = 1'b1;
                err_n          = 1'b1;
                cmd_cnt_n      = '0;
                wdf_cnt_n      = '0;
                rd_cnt_n       = '0;
                app_en_n       = 1'b0;
                app_wdf_wren_n = 1'b0;
            end else begin
                wd_cnt_n = wd_cnt + WD_W'(1);
            end
        end
`endif
        app_wdf_end_n = app_wdf_wren_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_INIT;
            cmd_cnt      <= '0;
            wdf_cnt      <= '0;
            rd_cnt       <= '0;
            wdata_hi     <= '0;
            app_addr     <= '0;
            app_cmd      <= '0;
            app_en       <= 1'b0;
            app_wdf_data <= '0;
            app_wdf_wren <= 1'b0;
            app_wdf_end  <= 1'b0;
            data_o       <= '0;
            ack_o        <= 1'b0;
        end else begin
            state        <= state_n;
            cmd_cnt      <= cmd_cnt_n;
            wdf_cnt      <= wdf_cnt_n;
            rd_cnt       <= rd_cnt_n;
            wdata_hi     <= wdata_hi_n;
            app_addr     <= app_addr_n;
            app_cmd      <= app_cmd_n;
            app_en       <= app_en_n;
            app_wdf_data <= app_wdf_data_n;
            app_wdf_wren <= app_wdf_wren_n;
            app_wdf_end  <= app_wdf_end_n;
            data_o       <= data_o_n;
            ack_o        <= ack_n;
        end
    end

`ifdef DDR3_BRIDGE_WATCHDOG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt <= '0;
            err_o  <= 1'b0;
        end else begin
            wd_cnt <= wd_cnt_n;
            err_o  <= err_n;
        end
    end
`endif

endmodule

// File: tb/tb_ddr3_line_bridge.sv
// Self-checking bench for ddr3_line_bridge: a small MIG behavioural model
// (command/data FIFOs, beat memory, fixed read latency) plus a line-level
// reference memory. Table vectors, hand sequences and random operations.
module tb_ddr3_line_bridge;
    localparam int unsigned AW = 27;
    localparam int unsigned DW = 128;

    logic           clk = 1'b0;
    logic           rst;
    logic [28:0]    addr_i;
    logic [255:0]   data_i;
    logic [255:0]   data_o;
    logic           we_i, rd_i, ack_o, err_o, init_calib_complete;
    logic [AW-1:0]  app_addr;
    logic [2:0]     app_cmd;
    logic           app_en, app_rdy;
    logic [DW-1:0]  app_wdf_data;
    logic [DW/8-1:0] app_wdf_mask;
    logic           app_wdf_wren, app_wdf_end, app_wdf_rdy;
    logic [DW-1:0]  app_rd_data;
    logic           app_rd_data_valid;

    always #5 clk = ~clk;

    ddr3_line_bridge #(
        .APP_ADDR_WIDTH (AW),
        .APP_DATA_WIDTH (DW),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .addr_i              (addr_i),
        .data_i              (data_i),
        .data_o              (data_o),
        .we_i                (we_i),
        .rd_i                (rd_i),
        .ack_o               (ack_o),
        .err_o               (err_o),
        .init_calib_complete (init_calib_complete),
        .app_addr            (app_addr),
        .app_cmd             (app_cmd),
        .app_en              (app_en),
        .app_rdy             (app_rdy),
        .app_wdf_data        (app_wdf_data),
        .app_wdf_mask        (app_wdf_mask),
        .app_wdf_wren        (app_wdf_wren),
        .app_wdf_end         (app_wdf_end),
        .app_wdf_rdy         (app_wdf_rdy),
        .app_rd_data         (app_rd_data),
        .app_rd_data_valid   (app_rd_data_valid)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- MIG model state ----------------
    typedef struct { logic [AW-1:0] addr; int due; } rret_t;
    int             cyc = 0;
    int             op_k = -1;
    int             cfg_c = 0, cfg_m = 0, cfg_l = 1;
    int             ack_total = 0, en_total = 0, rvalid_total = 0;
    bit             stray = 0;
    bit             hold_c = 0, hold_w = 0;
    logic [AW-1:0]  hold_addr;
    logic [2:0]     hold_cmd;
    logic [DW-1:0]  hold_wdata;
    logic [AW-1:0]  wcmd_q[$];
    logic [DW-1:0]  wdat_q[$];
    logic [AW-1:0]  op_wcmd[$];
    logic [AW-1:0]  op_rcmd[$];
    logic [DW-1:0]  op_wdat[$];
    rret_t          rpend[$];
    logic [DW-1:0]  mig_mem [logic [AW-1:0]];
    logic [255:0]   ref_mem [logic [22:0]];

    // Called once per cycle just after the falling edge.
    task automatic mig_model();
        rret_t r;
        if (ack_o)  ack_total++;
        if (app_en) en_total++;
        if (hold_c) begin
            chk("cmd_hold_en", app_en, 1'b1);
            chk("cmd_hold_addr", app_addr, hold_addr);
            chk("cmd_hold_cmd", app_cmd, hold_cmd);
        end
        if (hold_w) begin
            chk("wdf_hold_wren", app_wdf_wren, 1'b1);
            chk("wdf_hold_data", app_wdf_data, hold_wdata);
        end
        app_rdy     = !(op_k >= 1 && op_k <= cfg_c);
        app_wdf_rdy = !(op_k >= 2 && op_k < 2 + cfg_m);
        hold_c     = app_en && !app_rdy;
        hold_addr  = app_addr;
        hold_cmd   = app_cmd;
        hold_w     = app_wdf_wren && !app_wdf_rdy;
        hold_wdata = app_wdf_data;
        if (app_en && app_rdy) begin
            if (app_cmd == 3'b000) begin
                wcmd_q.push_back(app_addr);
                op_wcmd.push_back(app_addr);
            end else if (app_cmd == 3'b001) begin
                op_rcmd.push_back(app_addr);
                rpend.push_back('{addr: app_addr, due: cyc + cfg_l});
            end
        end
        if (app_wdf_wren && app_wdf_rdy) begin
            wdat_q.push_back(app_wdf_data);
            op_wdat.push_back(app_wdf_data);
            chk("wdf_end", app_wdf_end, 1'b1);
        end
        while (wcmd_q.size() > 0 && wdat_q.size() > 0) begin
            logic [AW-1:0] a;
            a = wcmd_q.pop_front();
            mig_mem[a] = wdat_q.pop_front();
        end
        app_rd_data_valid = 1'b0;
        app_rd_data = {$urandom(), $urandom(), $urandom(), $urandom()};
        if (stray) begin
            app_rd_data_valid = 1'b1;
            stray = 0;
        end else if (rpend.size() > 0 && rpend[0].due <= cyc) begin
            r = rpend.pop_front();
            app_rd_data_valid = 1'b1;
            app_rd_data = mig_mem.exists(r.addr) ? mig_mem[r.addr] : '0;
            rvalid_total++;
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        op_k = -1;
        repeat (n) begin
            @(negedge clk);
            mig_model();
        end
    endtask

    // ---------------- operation vectors ----------------
    typedef struct {
        bit           we;
        bit           rd;
        logic [28:0]  addr;
        logic [255:0] data;
        int           c;      // app_rdy low for cycles 1..c
        int           m;      // app_wdf_rdy low for cycles 2..2+m-1
        int           l;      // read return latency
        int           hold;   // cycles requests stay high after ack
        int           lat;    // expected request-to-ack cycles
    } vec_t;

    task automatic run_op(input vec_t v, input string tag);
        int            got;
        int            ack0;
        logic [22:0]   line;
        logic [AW-1:0] base;
        logic [255:0]  exp_line, got_data;
        line     = v.addr[22:0];
        base     = {line, 4'b0000};
        exp_line = ref_mem.exists(line) ? ref_mem[line] : '0;
        op_wcmd.delete(); op_rcmd.delete(); op_wdat.delete();
        ack0  = ack_total;
        cfg_c = v.c; cfg_m = v.m; cfg_l = v.l;
        got   = -1;
        got_data = '0;
        for (int k = 0; k < 200 && got < 0; k++) begin
            @(negedge clk);
            op_k = k;
            if (k == 0) begin
                we_i = v.we; rd_i = v.rd; addr_i = v.addr; data_i = v.data;
            end
            if (ack_o) begin
                got = k;
                got_data = data_o;
            end
            mig_model();
        end
        op_k = -1;
        repeat (v.hold) begin
            @(negedge clk);
            mig_model();
        end
        we_i = 1'b0; rd_i = 1'b0;
        idle(3);
        chk({tag, "_lat"}, 256'(got), 256'(v.lat));
        chk({tag, "_acks"}, 256'(ack_total - ack0), 256'(1));
        chk({tag, "_ncmd"}, 256'(op_wcmd.size() + op_rcmd.size()), 256'(2));
        if (v.we) begin
            chk({tag, "_nwcmd"}, 256'(op_wcmd.size()), 256'(2));
            chk({tag, "_nwdat"}, 256'(op_wdat.size()), 256'(2));
            if (op_wcmd.size() == 2 && op_wdat.size() == 2) begin
                chk({tag, "_waddr0"}, op_wcmd[0], base);
                chk({tag, "_waddr1"}, op_wcmd[1], base + AW'(8));
                chk({tag, "_wdat0"}, op_wdat[0], v.data[127:0]);
                chk({tag, "_wdat1"}, op_wdat[1], v.data[255:128]);
            end
            ref_mem[line] = v.data;
        end else begin
            chk({tag, "_nrcmd"}, 256'(op_rcmd.size()), 256'(2));
            if (op_rcmd.size() == 2) begin
                chk({tag, "_raddr0"}, op_rcmd[0], base);
                chk({tag, "_raddr1"}, op_rcmd[1], base + AW'(8));
            end
            chk({tag, "_rdata"}, got_data, exp_line);
            chk({tag, "_rdata_hold"}, data_o, exp_line);
        end
    endtask

    localparam logic [255:0] D1 = {128'h0123456789ABCDEFFEDCBA9876543210,
                                   128'h89ABCDEF0123456776543210FEDCBA98};
    localparam logic [255:0] D2 = {128'hDEADBEEF_00000000_11111111_22222222,
                                   128'h33333333_44444444_55555555_CAFEF00D};
    localparam logic [255:0] D3 = {128'hA5A5A5A5_5A5A5A5A_A5A5A5A5_5A5A5A5A, '0} | 256'h1;
    localparam logic [255:0] D4 = {128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF,
                                   128'h00000000_00000000_00000000_00000000};
    localparam logic [255:0] D5 = {128'h13579BDF_2468ACE0_0F1E2D3C_4B5A6978,
                                   128'h87654321_FEDCBA98_76543210_0BADC0DE};

    vec_t vecs [11];

    initial begin
        int          ack0, en0, rv0, got;
        vec_t        r;
        logic [22:0] pool [6];

        vecs[0]  = '{1, 0, 29'h10,        D1, 0, 0, 1, 0, 3};
        vecs[1]  = '{0, 1, 29'h10,        '0, 0, 0, 2, 0, 5};
        vecs[2]  = '{1, 0, 29'h20,        D2, 5, 3, 1, 0, 8};
        vecs[3]  = '{0, 1, 29'h20,        '0, 0, 0, 1, 0, 4};
        vecs[4]  = '{1, 1, 29'h30,        D3, 0, 0, 1, 4, 3};
        vecs[5]  = '{0, 1, 29'h30,        '0, 2, 0, 3, 0, 8};
        vecs[6]  = '{1, 0, 29'h1F70_0005, D4, 0, 4, 1, 0, 7};
        vecs[7]  = '{0, 1, 29'h0070_0005, '0, 1, 0, 1, 0, 5};
        vecs[8]  = '{0, 1, 29'h007F_FFFF, '0, 0, 0, 1, 0, 4};
        vecs[9]  = '{1, 0, 29'h007F_FFFF, D5, 1, 1, 1, 0, 4};
        vecs[10] = '{0, 1, 29'h1FFF_FFFF, '0, 0, 0, 4, 0, 7};
        pool = '{23'h0, 23'h1, 23'h55, 23'h2AAAA, 23'h7FFFFE, 23'h7FFFFF};

        rst = 1'b1; we_i = 1'b0; rd_i = 1'b0; addr_i = '0; data_i = '0;
        init_calib_complete = 1'b0;
        app_rdy = 1'b1; app_wdf_rdy = 1'b1; app_rd_data = '0; app_rd_data_valid = 1'b0;
        idle(3);
        chk("rst_ack", ack_o, 1'b0);
        chk("rst_app_en", app_en, 1'b0);
        chk("rst_wren", app_wdf_wren, 1'b0);
        chk("rst_wdf_end", app_wdf_end, 1'b0);
        chk("rst_err", err_o, 1'b0);
        chk("rst_app_addr", app_addr, '0);
        chk("rst_app_cmd", app_cmd, '0);
        chk("rst_wdf_data", app_wdf_data, '0);
        chk("rst_data_o", data_o, '0);
        chk("rst_mask", app_wdf_mask, '0);

        // Calibration: nothing happens until init_calib_complete, then one ack.
        rst = 1'b0;
        ack0 = ack_total; en0 = en_total;
        idle(20);
        chk("calib_wait_acks", 256'(ack_total - ack0), 256'(0));
        chk("calib_wait_en", 256'(en_total - en0), 256'(0));
        init_calib_complete = 1'b1;
        idle(6);
        chk("calib_acks", 256'(ack_total - ack0), 256'(1));
        chk("calib_en", 256'(en_total - en0), 256'(0));

        for (int i = 0; i < 11; i++) run_op(vecs[i], $sformatf("vec%0d", i));

        // Reset in the middle of a read, after the first beat has returned.
        op_wcmd.delete(); op_rcmd.delete(); op_wdat.delete();
        cfg_c = 0; cfg_m = 0; cfg_l = 2;
        rv0 = rvalid_total;
        for (int k = 0; k < 50 && rvalid_total == rv0; k++) begin
            @(negedge clk);
            op_k = k;
            if (k == 0) begin rd_i = 1'b1; addr_i = 29'h10; end
            mig_model();
        end
        chk("mid_first_beat", 256'(rvalid_total - rv0), 256'(1));
        @(negedge clk);
        rst = 1'b1; rd_i = 1'b0; op_k = -1;
        #1;
        chk("mid_rst_ack", ack_o, 1'b0);
        chk("mid_rst_en", app_en, 1'b0);
        chk("mid_rst_addr", app_addr, '0);
        chk("mid_rst_cmd", app_cmd, '0);
        chk("mid_rst_data_o", data_o, '0);
        hold_c = 0; hold_w = 0;
        mig_model();
        idle(2);
        rst = 1'b0;
        ack0 = ack_total;
        idle(6);
        chk("mid_recal_acks", 256'(ack_total - ack0), 256'(1));
        stray = 1;
        idle(3);
        chk("stray_data_o", data_o, '0);
        chk("stray_acks", 256'(ack_total - ack0), 256'(1));
        run_op('{0, 1, 29'h10, '0, 0, 0, 2, 0, 5}, "post_rst_rd");

        // Randomised operations against the line-level reference.
        for (int i = 0; i < 40; i++) begin
            r.we   = 1'($urandom_range(0, 1));
            r.rd   = r.we ? 1'($urandom_range(0, 1)) : 1'b1;
            r.addr = {6'($urandom_range(0, 63)), pool[$urandom_range(0, 5)]};
            for (int j = 0; j < 8; j++) r.data[j*32 +: 32] = $urandom();
            r.c    = $urandom_range(0, 3);
            r.m    = $urandom_range(0, 3);
            r.l    = $urandom_range(1, 4);
            r.hold = $urandom_range(0, 2);
            r.lat  = r.we ? 3 + ((r.c > r.m) ? r.c : r.m) : 3 + r.c + r.l;
            run_op(r, $sformatf("rnd%0d", i));
        end

`ifdef DDR3_BRIDGE_WATCHDOG_EN
        // Command channel never ready: watchdog aborts at cycle 16.
        cfg_c = 1000; cfg_m = 0; cfg_l = 1;
        got = -1;
        for (int k = 0; k < 100 && got < 0; k++) begin
            @(negedge clk);
            op_k = k;
            if (k == 0) begin we_i = 1'b1; addr_i = 29'h40; data_i = D2; end
            if (ack_o) begin
                got = k;
                hold_c = 0;
                chk("wd_err_at_ack", err_o, 1'b1);
            end
            mig_model();
        end
        we_i = 1'b0;
        chk("wd_lat", 256'(got), 256'(16));
        idle(10);
        chk("wd_err_sticky", err_o, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("wd_err_rst", err_o, 1'b0);
        wcmd_q.delete(); wdat_q.delete();
        cfg_c = 0;
        mig_model();
        rst = 1'b0;
        idle(6);
`else
        chk("err_tied", err_o, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
